ex_mem_skid_stage: RTL

Parametrised EX/MEM pipeline stage: registers the execute-stage result bundle and decodes memory-access lane information for XLEN = 32 or 64. It replaces the plain load-enabled EX/MEM register with a valid/ready handshake, a 2-entry skid buffer for full-throughput backpressure, flush, and misalignment detection. It sits between the ALU/branch logic and the data-cache request port.

---
 rtl/ex_mem_skid_stage.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage with valid/ready handshake, 2-entry skid buffer, flush,
// and memory lane decode (byte enables, store-data lane shift, misalignment).
module ex_mem_skid_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [2:0]        in_funct3,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_alu_res,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [XLEN-1:0]   in_u_imm,
    input  logic              in_br_en,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [2:0]        out_funct3,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_br_en,
    output logic [REG_W-1:0]  out_rd,
    output logic [XLEN-1:0]   out_alu_res,
    output logic [XLEN-1:0]   out_u_imm,
    output logic [XLEN-1:0]   out_addr_aligned,
    output logic [$clog2(XLEN/8)-1:0] out_bit_shift,
    output logic [XLEN/8-1:0] out_mem_byte_enable,
    output logic [XLEN-1:0]   out_wdata,
    output logic              out_misaligned
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [2:0]        funct3;
        logic              mem_read;
        logic              mem_write;
        logic [XLEN-1:0]   pc;
        logic              br_en;
        logic [REG_W-1:0]  rd;
        logic [XLEN-1:0]   alu_res;
        logic [XLEN-1:0]   u_imm;
        logic [XLEN-1:0]   addr_aligned;
        logic [OFF_W-1:0]  bit_shift;
        logic [NB-1:0]     byte_enable;
        logic [XLEN-1:0]   wdata;
        logic              misaligned;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nx;
    entry_t ent_p0, main_p1, skid_p1;
    logic   load_main_in, load_main_skid, load_skid;
    logic   in_fire, out_fire;

    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] lo_mask;
    logic [NB-1:0]    base_mask;
    logic             size_legal;

    // p0: combinational lane decode on the incoming entry
    always_comb begin
        off        = in_alu_res[OFF_W-1:0];
        base_mask  = NB'(1);
        lo_mask    = '0;
        size_legal = 1'b1;
        case (in_funct3[1:0])
            2'b00: begin base_mask = NB'(1);     lo_mask = '0;         end
            2'b01: begin base_mask = NB'(3);     lo_mask = OFF_W'(1);  end
            2'b10: begin base_mask = NB'(15);    lo_mask = OFF_W'(3);  end
            default: begin
                base_mask  = NB'(8'hFF);
                lo_mask    = OFF_W'(7);
                size_legal = (XLEN == 64);
            end
        endcase

        ent_p0              = '0;
        ent_p0.ctrl         = in_ctrl;
        ent_p0.funct3       = in_funct3;
        ent_p0.mem_read     = in_mem_read;
        ent_p0.mem_write    = in_mem_write;
        ent_p0.pc           = in_pc;
        ent_p0.br_en        = in_br_en;
        ent_p0.rd           = in_rd;
        ent_p0.alu_res      = in_alu_res;
        ent_p0.u_imm        = in_u_imm;
        ent_p0.addr_aligned = {in_alu_res[XLEN-1:OFF_W], OFF_W'(0)};
        ent_p0.bit_shift    = off;
        ent_p0.wdata        = in_mem_write ? (in_wdata << {off, 3'b000}) : in_wdata;

        if (!(in_mem_read || in_mem_write)) begin
            ent_p0.byte_enable = '1;
            ent_p0.misaligned  = 1'b0;
        end else if (size_legal && ((off & lo_mask) == '0)) begin
            ent_p0.byte_enable = base_mask << off;
            ent_p0.misaligned  = 1'b0;
        end else begin
            ent_p0.byte_enable = '0;
            ent_p0.misaligned  = 1'b1;
        end
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_nx     = ONE;
                    load_main_in = 1'b1;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_nx  = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nx = EMPTY;
                    end
                end
                FULL: if (out_fire) begin
                    state_nx       = ONE;
                    load_main_skid = 1'b1;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // p1: main (output) register and skid register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            main_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            state <= state_nx;
            if (load_main_in)
                main_p1 <= ent_p0;
            else if (load_main_skid)
                main_p1 <= skid_p1;
            if (load_skid)
                skid_p1 <= ent_p0;
        end
    end

    assign out_ctrl            = main_p1.ctrl;
    assign out_funct3          = main_p1.funct3;
    assign out_mem_read        = main_p1.mem_read;
    assign out_mem_write       = main_p1.mem_write;
    assign out_pc              = main_p1.pc;
    assign out_br_en           = main_p1.br_en;
    assign out_rd              = main_p1.rd;
    assign out_alu_res         = main_p1.alu_res;
    assign out_u_imm           = main_p1.u_imm;
    assign out_addr_aligned    = main_p1.addr_aligned;
    assign out_bit_shift       = main_p1.bit_shift;
    assign out_mem_byte_enable = main_p1.byte_enable;
    assign out_wdata           = main_p1.wdata;
    assign out_misaligned      = main_p1.misaligned;

endmodule
